instr_sequencer: RTL and testbench

Multi-cycle instruction sequencer for the 4-bit-opcode CPU. It sits between the combinational `control` decoder and the datapath. It steps each instruction through fetch, decode, execute, memory and writeback states, and turns the decoder's level signals into single-cycle datapath strobes. It also owns the memory request/ready handshake and a memory-timeout fault.

---
 rtl/cpu_pkg.sv | 36 +++
 rtl/mem_wait_timer.sv | 30 +++
 rtl/instr_sequencer.sv | 135 +++++++++++++
 tb/tb_instr_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the 4-bit-opcode CPU: sequencer states and opcode constants.
// Combinational only; no latency, no flow control.
package cpu_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_FETCH  = 3'd1;
   localparam logic [2:0] ST_DECODE = 3'd2;
   localparam logic [2:0] ST_EXEC   = 3'd3;
   localparam logic [2:0] ST_MEM    = 3'd4;
   localparam logic [2:0] ST_WB     = 3'd5;
   localparam logic [2:0] ST_FAULT  = 3'd7;

   typedef enum logic [2:0] {
      S_IDLE   = ST_IDLE,
      S_FETCH  = ST_FETCH,
      S_DECODE = ST_DECODE,
      S_EXEC   = ST_EXEC,
      S_MEM    = ST_MEM,
      S_WB     = ST_WB,
      S_FAULT  = ST_FAULT
   } state_t;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_CMP = 4'h5;
   localparam logic [3:0] OP_LD  = 4'h8;
   localparam logic [3:0] OP_ST  = 4'h9;
   localparam logic [3:0] OP_JMP = 4'hA;
   localparam logic [3:0] OP_BEQ = 4'hE;
   localparam logic [3:0] OP_BNE = 4'hF;

   // States that hold a memory request open and are subject to the wait timeout.
   function automatic logic in_wait_state(input state_t s);
      return (s == S_FETCH) || (s == S_MEM);
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive memory-wait cycles; expired is combinational in the cycle the limit is hit.
// One-cycle latency on the count; MAX_WAIT of 0 never expires.
module mem_wait_timer #(
   parameter int MAX_WAIT = 15
) (
   input  logic clk,
   input  logic resetN,
   input  logic clear,
   input  logic count,
   output logic expired
);

   localparam int W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (count && (cnt != W'(MAX_WAIT))) begin
         cnt <= cnt + 1'b1;
      end
   end

   // Only a cycle that is itself a wait cycle can expire, so memReady on the limit cycle wins.
   assign expired = (MAX_WAIT != 0) && count && (cnt == W'(MAX_WAIT - 1));

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/wb sequencer turning decoder levels into one-cycle datapath strobes.
// 3-5 cycles per instruction plus one per memory wait cycle; stalls on memReady, faults after MAX_WAIT.
module instr_sequencer
   import cpu_pkg::*;
#(
   parameter int MAX_WAIT = 15,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             resetN,
   input  logic             run,
   input  logic [3:0]       opcode,
   input  logic             branch,
   input  logic             jump,
   input  logic             compare,
   input  logic             memRead,
   input  logic             memWrite,
   input  logic             regLoad,
   input  logic             condTrue,
   input  logic             memReady,
   output logic             memReq,
   output logic             memWe,
   output logic             memAddrSel,
   output logic             irLoad,
   output logic             pcInc,
   output logic             pcLoad,
   output logic             aluEn,
   output logic             flagLoad,
   output logic             regWe,
   output logic             instrDone,
   output logic             busy,
   output logic             fault,
   output logic [CNT_W-1:0] instrCount
);

   state_t state, state_nxt;
   logic   retire;
   logic   wait_cnt, wait_clr, expired;

   // Any cycle that is not a stalled FETCH/MEM restarts the consecutive-wait count.
   assign wait_cnt = in_wait_state(state) && !memReady;
   assign wait_clr = !wait_cnt;

   mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
      .clk     (clk),
      .resetN  (resetN),
      .clear   (wait_clr),
      .count   (wait_cnt),
      .expired (expired)
   );

   always_comb begin
      state_nxt  = state;
      retire     = 1'b0;
      memReq     = 1'b0;
      memWe      = 1'b0;
      memAddrSel = 1'b0;
      irLoad     = 1'b0;
      pcInc      = 1'b0;
      pcLoad     = 1'b0;
      aluEn      = 1'b0;
      flagLoad   = 1'b0;
      regWe      = 1'b0;
      case (state)
         S_IDLE: begin
            if (run) state_nxt = S_FETCH;
         end
         S_FETCH: begin
            memReq = 1'b1;
            if (memReady) begin
               irLoad    = 1'b1;
               pcInc     = 1'b1;
               state_nxt = S_DECODE;
            end else if (expired) begin
               state_nxt = S_FAULT;
            end
         end
         S_DECODE: begin
            state_nxt = S_EXEC;
         end
         S_EXEC: begin
            aluEn    = 1'b1;
            flagLoad = compare;
            if (memRead || memWrite) begin
               state_nxt = S_MEM;
            end else if (jump || branch) begin
               pcLoad = (opcode == OP_JMP) || condTrue;
               retire = 1'b1;
            end else if (regLoad) begin
               state_nxt = S_WB;
            end else begin
               retire = 1'b1;
            end
         end
         S_MEM: begin
            memReq     = 1'b1;
            memAddrSel = 1'b1;
            memWe      = memWrite;
            if (memReady) begin
               // Stores retire here even if the decoder also flags regLoad.
               if (memWrite) retire = 1'b1;
               else          state_nxt = S_WB;
            end else if (expired) begin
               state_nxt = S_FAULT;
            end
         end
         S_WB: begin
            regWe  = 1'b1;
            retire = 1'b1;
         end
         S_FAULT: begin
            state_nxt = S_FAULT;
         end
         default: begin
            state_nxt = S_FAULT;
         end
      endcase
      if (retire) state_nxt = run ? S_FETCH : S_IDLE;
   end

   assign instrDone = retire;
   assign busy      = (state != S_IDLE) && (state != S_FAULT);
   assign fault     = (state == S_FAULT);

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state      <= S_IDLE;
         instrCount <= '0;
      end else begin
         state <= state_nxt;
         if (retire) instrCount <= instrCount + 1'b1;
      end
   end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: per-instruction expectations queued at issue, checked at retire.
// Small wait limit and counter width keep fault and wrap scenarios short.
module tb_instr_sequencer;
   import cpu_pkg::*;

   localparam int MW = 4;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          resetN, run, branch, jump, compare, memRead, memWrite, regLoad, condTrue, memReady;
   logic [3:0]    opcode;
   logic          memReq, memWe, memAddrSel, irLoad, pcInc, pcLoad, aluEn, flagLoad, regWe;
   logic          instrDone, busy, fault;
   logic [CW-1:0] instrCount;

   instr_sequencer #(.MAX_WAIT(MW), .CNT_W(CW)) dut (
      .clk(clk), .resetN(resetN), .run(run), .opcode(opcode),
      .branch(branch), .jump(jump), .compare(compare), .memRead(memRead),
      .memWrite(memWrite), .regLoad(regLoad), .condTrue(condTrue), .memReady(memReady),
      .memReq(memReq), .memWe(memWe), .memAddrSel(memAddrSel), .irLoad(irLoad),
      .pcInc(pcInc), .pcLoad(pcLoad), .aluEn(aluEn), .flagLoad(flagLoad), .regWe(regWe),
      .instrDone(instrDone), .busy(busy), .fault(fault), .instrCount(instrCount)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            lat, ir_cyc, alu_cyc, we_cyc;
      int            n_req, n_sel, n_memwe, n_flag, n_pcload, n_regwe, n_ir, n_pcinc, n_alu;
      logic [CW-1:0] cnt;
   } exp_t;

   exp_t          sb[$];
   int            n_assert = 0;
   int            n_fail   = 0;
   logic [CW-1:0] model_cnt;
   bit            idle;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
      n_assert++;
      assert (obs === req) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, req);
      end
   endtask

   // Reference decoder standing in for the control block.
   task automatic set_op(input logic [3:0] op);
      opcode   = op;
      branch   = (op == OP_BEQ) || (op == OP_BNE);
      jump     = (op >= OP_JMP) && (op < OP_BEQ);
      compare  = (op == OP_CMP) || ((op > OP_JMP) && (op < OP_BEQ));
      memRead  = (op == OP_LD);
      memWrite = (op == OP_ST);
      regLoad  = ((op >= 4'h1) && (op <= 4'h4)) || (op == OP_LD) || (op == OP_ST);
   endtask

   // Starts and ends at posedge+1; fw/mw are memory wait cycles in FETCH/MEM.
   task automatic do_instr(input logic [3:0] op, input logic cond, input int fw, input int mw,
                           input logic run_after);
      exp_t e;
      int   c, base, g_ir, g_alu, g_we;
      int   n_req, n_sel, n_memwe, n_flag, n_pcload, n_regwe, n_ir, n_pcinc, n_alu;
      bit   done, memop, jb, is_load, is_store;
      set_op(op);
      condTrue = cond;
      memop    = memRead || memWrite;
      jb       = jump || branch;
      is_store = memWrite;
      is_load  = memRead && !memWrite;
      if (is_load)       base = 5;
      else if (is_store) base = 4;
      else if (jb)       base = 3;
      else if (regLoad)  base = 4;
      else               base = 3;
      e.lat      = base + fw + (memop ? mw : 0);
      e.ir_cyc   = fw + 1;
      e.alu_cyc  = fw + 3;
      e.n_ir     = 1;
      e.n_pcinc  = 1;
      e.n_alu    = 1;
      e.n_flag   = compare ? 1 : 0;
      e.n_pcload = (jb && ((op == OP_JMP) || cond)) ? 1 : 0;
      e.n_regwe  = (is_load || (!memop && !jb && regLoad)) ? 1 : 0;
      e.we_cyc   = (e.n_regwe != 0) ? e.lat : 0;
      e.n_req    = fw + 1 + (memop ? mw + 1 : 0);
      e.n_sel    = memop ? mw + 1 : 0;
      e.n_memwe  = is_store ? mw + 1 : 0;
      model_cnt  = model_cnt + 1'b1;
      e.cnt      = model_cnt;
      sb.push_back(e);

      if (idle) begin
         run = 1'b1;
         memReady = 1'b1;
         @(negedge clk);
         chk("idle_strobes", {memReq, memWe, irLoad, pcInc, aluEn, regWe, instrDone}, 0);
         chk("idle_busy", busy, 0);
         @(posedge clk); #1;
      end

      c = 0; done = 0; g_ir = 0; g_alu = 0; g_we = 0;
      n_req = 0; n_sel = 0; n_memwe = 0; n_flag = 0; n_pcload = 0; n_regwe = 0;
      n_ir = 0; n_pcinc = 0; n_alu = 0;
      while (!done && (c < 40)) begin
         c++;
         run      = (c >= 2) ? run_after : 1'b1;
         memReady = !((c <= fw) || (memop && (c >= fw + 4) && (c <= fw + 3 + mw)));
         @(negedge clk);
         if (memReq)     n_req++;
         if (memAddrSel) n_sel++;
         if (memWe)      n_memwe++;
         if (flagLoad)   n_flag++;
         if (pcLoad)     n_pcload++;
         if (pcInc)      n_pcinc++;
         if (irLoad)  begin n_ir++;    if (g_ir == 0)  g_ir  = c; end
         if (aluEn)   begin n_alu++;   if (g_alu == 0) g_alu = c; end
         if (regWe)   begin n_regwe++; if (g_we == 0)  g_we  = c; end
         if (instrDone) done = 1;
         @(posedge clk); #1;
      end
      chk("retired", done, 1);
      e = sb.pop_front();
      chk("latency", c, e.lat);
      chk("irload_cycle", g_ir, e.ir_cyc);
      chk("aluen_cycle", g_alu, e.alu_cyc);
      chk("regwe_cycle", g_we, e.we_cyc);
      chk("n_memreq", n_req, e.n_req);
      chk("n_addrsel", n_sel, e.n_sel);
      chk("n_memwe", n_memwe, e.n_memwe);
      chk("n_flagload", n_flag, e.n_flag);
      chk("n_pcload", n_pcload, e.n_pcload);
      chk("n_regwe", n_regwe, e.n_regwe);
      chk("n_irload_pcinc", {n_ir[15:0], n_pcinc[15:0]}, {e.n_ir[15:0], e.n_pcinc[15:0]});
      chk("n_aluen", n_alu, e.n_alu);
      chk("instr_count", instrCount, e.cnt);
      chk("busy_after", busy, run_after);
      idle = !run_after;
   endtask

   initial begin
      resetN = 1'b0; run = 1'b1; condTrue = 1'b0; memReady = 1'b0;
      set_op(OP_NOP);
      model_cnt = '0;
      idle = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_strobes", {memReq, memWe, memAddrSel, irLoad, pcInc, pcLoad, aluEn, flagLoad, regWe, instrDone}, 0);
      chk("rst_busy_fault", {busy, fault}, 0);
      chk("rst_count", instrCount, 0);
      @(posedge clk); #1;
      resetN = 1'b1;

      do_instr(4'h3,   0, 0, 0, 1);   // ALU op with regLoad
      do_instr(OP_LD,  0, 0, 2, 1);   // load, two MEM wait cycles
      do_instr(OP_ST,  0, 0, 0, 1);   // store, regLoad must be ignored
      do_instr(4'hB,   0, 0, 0, 1);   // conditional jump, not taken
      do_instr(OP_JMP, 0, 0, 0, 1);   // unconditional jump
      do_instr(OP_BEQ, 1, 0, 0, 1);   // branch taken
      do_instr(OP_CMP, 0, 1, 0, 1);   // compare with one fetch wait
      do_instr(OP_NOP, 0, 3, 0, 0);   // longest fetch wait short of fault, then IDLE
      for (int i = 0; i < 8; i++) do_instr(OP_NOP, 0, 0, 0, (i == 7) ? 1'b0 : 1'b1);
      chk("wrap_zero", instrCount, 0);
      @(negedge clk);
      chk("idle_after_stop", busy, 0);
      @(posedge clk); #1;

      do_instr(OP_NOP, 0, 0, 0, 0);
      set_op(OP_NOP);
      run = 1'b1; memReady = 1'b0;
      @(negedge clk); @(posedge clk); #1;
      for (int k = 1; k <= MW; k++) begin
         memReady = 1'b0;
         @(negedge clk);
         chk("flt_memreq", memReq, 1);
         chk("flt_early", fault, 0);
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("flt_fault", fault, 1);
      chk("flt_busy", busy, 0);
      chk("flt_memreq_off", memReq, 0);
      memReady = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("flt_sticky", fault, 1);
      chk("flt_no_irload", irLoad, 0);
      resetN = 1'b0;
      #1;
      chk("flt_reset_fault", fault, 0);
      chk("flt_reset_count", instrCount, 0);
      @(posedge clk); #1;
      resetN = 1'b1;
      model_cnt = '0;
      idle = 1;

      do_instr(OP_NOP, 0, 0, 0, 1);
      set_op(4'h3);
      run = 1'b1; memReady = 1'b1;
      @(negedge clk); @(posedge clk); #1;
      @(negedge clk); @(posedge clk); #1;
      @(negedge clk);
      chk("midrst_alu_before", aluEn, 1);
      #1 resetN = 1'b0;
      #1;
      chk("midrst_strobes", {aluEn, regWe, instrDone, memReq}, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_count", instrCount, 0);
      @(posedge clk); #1;
      resetN = 1'b1;
      model_cnt = '0;
      idle = 1;
      do_instr(4'h3, 0, 0, 0, 0);

      chk("scoreboard_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
